// File: rtl/sample_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sample_sender
// Brief    : Dumps capture RAM newest-first, little-endian, over the UART
//            transmitter, pacing on transmit_busy.
// Revision : 1.0 - initial release
// ============================================================================
module sample_sender #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     sample_count,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [SAMPLE_WIDTH-1:0] mem_data,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    transmit_busy,
  output logic                    busy,
  output logic                    done
);

  localparam int NB = SAMPLE_WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0]       LAST_BYTE = BW'(NB - 1);
  localparam logic [ADDR_WIDTH:0] ONE_LEFT  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_HOLD  = 3'd4,
    S_NEXT  = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [BW-1:0]           byte_idx_q, byte_idx_d;
  logic [NB-1:0][7:0]      shreg_q, shreg_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    shreg_d     = shreg_q;
    tx_data_d   = tx_data_q;
    done_d      = 1'b0;
    tx_start    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (sample_count == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = start_addr;
            remaining_d = sample_count;
            byte_idx_d  = '0;
            state_d     = S_FETCH;
          end
        end
      end

      S_FETCH: state_d = S_LATCH;

      S_LATCH: begin
        shreg_d   = mem_data;
        tx_data_d = mem_data[7:0];
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (!transmit_busy) begin
          tx_start = 1'b1;
          state_d  = S_HOLD;
        end
      end

      // transmit_busy only becomes visible one cycle after tx_start
      S_HOLD: begin
        if (abort) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (byte_idx_q < LAST_BYTE) begin
          byte_idx_d = byte_idx_q + 1'b1;
          tx_data_d  = shreg_q[byte_idx_d];
          state_d    = S_SEND;
        end else begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        byte_idx_d  = '0;
        remaining_d = remaining_q - ONE_LEFT;
        addr_d      = addr_q - 1'b1;
        if (remaining_q == ONE_LEFT) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      byte_idx_q  <= '0;
      shreg_q     <= '0;
      tx_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      shreg_q     <= shreg_d;
      tx_data_q   <= tx_data_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr = addr_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sample_sender
// Brief    : Self-checking bench: RAM + UART transmitter models, byte-stream
//            reference model, table vectors, random dumps, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_sender;

  localparam int SW    = 32;
  localparam int AW    = 10;
  localparam int NB    = SW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   sample_count = '0;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_data;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          transmit_busy;
  logic          busy;
  logic          done;

  sample_sender #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .start_addr    (start_addr),
    .sample_count  (sample_count),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .transmit_busy (transmit_busy),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  // Synchronous-read sample RAM
  logic [SW-1:0] ram [DEPTH];
  always @(posedge clock) mem_data <= ram[mem_addr];

  // Transmitter: busy for busy_len cycles starting the cycle after tx_start
  int   tx_cnt = 0;
  int   busy_len = 0;
  logic force_busy = 1'b0;
  always @(posedge clock) begin
    if (tx_start)        tx_cnt <= busy_len;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign transmit_busy = (tx_cnt != 0) || force_busy;

  // Monitor, sampled on the falling edge
  int         cyc = 0;
  logic [7:0] got_q [$];
  int         got_cyc [$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       busy_at_done = 1'b0;
  int         busy_cnt = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (tx_start) begin
      got_q.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt     = done_cnt + 1;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  int         checks = 0;
  int         errors = 0;
  int         start_cyc = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: newest-first addresses modulo depth, each word little-endian
  task automatic build_exp(input int sa, input int cnt);
    int a;
    logic [SW-1:0] w;
    exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      a = (sa - i) & (DEPTH - 1);
      w = ram[a];
      for (int b = 0; b < NB; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic start_dump(input int sa, input int cnt);
    @(posedge clock); #1;
    start        = 1'b1;
    start_addr   = AW'(sa);
    sample_count = (AW + 1)'(cnt);
    start_cyc    = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base_done, input int bound);
    int n = 0;
    while (done_cnt == base_done && n < bound) begin
      @(negedge clock);
      n++;
    end
    chk({name, " done seen"}, (done_cnt > base_done) ? 1 : 0, 1);
    repeat (busy_len + 8) @(negedge clock);
  endtask

  task automatic check_stream(input string name, input int base, input int nexp);
    int nbad = 0;
    int ngot = got_q.size() - base;
    chk({name, " byte count"}, ngot, nexp);
    for (int i = 0; i < nexp && i < ngot && i < exp_q.size(); i++)
      if (got_q[base + i] !== exp_q[i]) nbad++;
    chk({name, " byte mismatches"}, nbad, 0);
  endtask

  task automatic run_vec(input string name, input int sa, input int cnt,
                         input int blen, input int nexp);
    int bt = got_q.size();
    int bd = done_cnt;
    int bb = busy_cnt;
    busy_len = blen;
    build_exp(sa, cnt);
    start_dump(sa, cnt);
    wait_done(name, bd, 20000);
    check_stream(name, bt, nexp);
    chk({name, " done pulses"}, done_cnt - bd, 1);
    chk({name, " busy at done"}, busy_at_done, 0);
    if (nexp > 0) begin
      chk({name, " first tx latency"}, got_cyc[bt] - start_cyc, 3);
    end else begin
      chk({name, " zero done cycle"}, done_cyc - start_cyc, 1);
      chk({name, " zero busy cycles"}, busy_cnt - bb, 0);
    end
  endtask

  typedef struct {
    int sa;
    int cnt;
    int blen;
    int exp_nbytes;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] lit [8];
    int bt, bd, n, rel_cyc;
    logic [7:0] held;

    vecs[0] = '{1,    3,    4,   12};   // wrap 1, 0, 1023
    vecs[1] = '{7,    0,    5,    0};   // zero count
    vecs[2] = '{1023, 1,    0,    4};
    vecs[3] = '{10,   5,    2,   20};
    vecs[4] = '{700,  1024, 0, 4096};   // every location once
    lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    ram[5] = 32'h4433_2211;
    ram[4] = 32'h8877_6655;

    repeat (3) @(posedge clock);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset tx_start", tx_start, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset mem_addr", mem_addr, 0);
    reset_n = 1'b1;

    // Basic dump against literal bytes
    busy_len = 10;
    bt = got_q.size();
    bd = done_cnt;
    start_dump(5, 2);
    wait_done("basic", bd, 2000);
    chk("basic byte count", got_q.size() - bt, 8);
    n = 0;
    for (int i = 0; i < 8 && bt + i < got_q.size(); i++)
      if (got_q[bt + i] !== lit[i]) n++;
    chk("basic literal mismatches", n, 0);
    chk("basic done pulses", done_cnt - bd, 1);
    chk("basic first tx latency", got_cyc[bt] - start_cyc, 3);
    chk("basic busy after", busy, 0);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i].sa, vecs[i].cnt,
                              vecs[i].blen, vecs[i].exp_nbytes);

    for (int r = 0; r < 6; r++) begin
      int c = $urandom_range(1, 6);
      run_vec($sformatf("rand%0d", r), $urandom_range(0, DEPTH - 1), c,
              $urandom_range(0, 15), c * NB);
    end

    // Backpressure: stall in SEND for 50 cycles
    force_busy = 1'b1;
    busy_len = 4;
    bt = got_q.size();
    bd = done_cnt;
    build_exp(200, 1);
    start_dump(200, 1);
    repeat (50) @(negedge clock);
    chk("stall tx_start count", got_q.size() - bt, 0);
    held = tx_data;
    chk("stall tx_data", held, exp_q[0]);
    @(posedge clock); #1;
    force_busy = 1'b0;
    rel_cyc = cyc;
    wait_done("stall", bd, 2000);
    check_stream("stall", bt, 4);
    if (got_q.size() > bt) begin
      chk("stall release cycle", got_cyc[bt] - rel_cyc, 0);
      chk("stall held byte", got_q[bt], held);
    end

    // Abort after the second byte of a 4-sample dump
    busy_len = 3;
    bt = got_q.size();
    bd = done_cnt;
    build_exp(300, 4);
    start_dump(300, 4);
    n = 0;
    while (got_q.size() - bt < 2 && n < 500) begin
      @(posedge clock);
      n++;
    end
    #1 abort = 1'b1;
    wait_done("abort", bd, 500);
    abort = 1'b0;
    check_stream("abort", bt, 2);
    chk("abort done pulses", done_cnt - bd, 1);
    chk("abort busy after", busy, 0);
    run_vec("after abort", 300, 4, 3, 16);

    // Stray start while busy is ignored
    busy_len = 2;
    bt = got_q.size();
    bd = done_cnt;
    build_exp(50, 3);
    start_dump(50, 3);
    repeat (5) @(posedge clock);
    #1;
    start = 1'b1;
    start_addr = AW'(900);
    sample_count = (AW + 1)'(7);
    @(posedge clock); #1;
    start = 1'b0;
    wait_done("stray", bd, 2000);
    check_stream("stray", bt, 12);
    chk("stray done pulses", done_cnt - bd, 1);

    // Reset mid-dump
    bt = got_q.size();
    bd = done_cnt;
    start_dump(600, 4);
    n = 0;
    while (got_q.size() - bt < 3 && n < 500) begin
      @(posedge clock);
      n++;
    end
    #1 reset_n = 1'b0;
    @(posedge clock); #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset tx_start", tx_start, 0);
    chk("midreset tx_data", tx_data, 0);
    chk("midreset mem_addr", mem_addr, 0);
    reset_n = 1'b1;
    bt = got_q.size();
    repeat (40) @(negedge clock);
    chk("midreset later tx_start", got_q.size() - bt, 0);
    chk("midreset done pulses", done_cnt - bd, 0);
    run_vec("after reset", 600, 2, 1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
